tile_conv2d_stream: RTL and testbench

- Parametrised successor to the fixed 3x3, 8-pixel tile convolution engine.
- Streams one tile in raster order (PIX_PER_CLK pixels per beat) and produces a same-size KSIZE x KSIZE convolved tile, zero-padded at the borders.
- Adds runtime tile size, ready/valid backpressure on both sides, an output rounding shift with saturation, and frame start/last/done control.
- Sits between the tile DMA reader and the tile writeback DMA.

---
 rtl/tile_conv2d_stream.sv | 238 +++++++++++++++++++++++
 tb/tb_tile_conv2d_stream.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/tile_conv2d_stream.sv
// rtl/tile_conv2d_stream.sv - streaming KSIZE x KSIZE tile convolution with zero padding and ready/valid flow control
// Optional feature macro: TILE_CONV2D_RELU_EN clamps negative shifted results to zero before saturation.
module tile_conv2d_stream #(
  parameter int PIX_PER_CLK = 8,
  parameter int DATA_W      = 8,
  parameter int COEF_W      = 8,
  parameter int KSIZE       = 3,
  parameter int MAX_W       = 64,
  parameter int OUT_W       = 16,
  parameter int ACC_W       = DATA_W + COEF_W + 2*$clog2(KSIZE) + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [15:0]                      cfg_w,
  input  logic [15:0]                      cfg_h,
  input  logic [4:0]                       cfg_shift,
  input  logic [KSIZE*KSIZE*COEF_W-1:0]    kernel,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [PIX_PER_CLK*DATA_W-1:0]    in_pixels,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [PIX_PER_CLK*OUT_W-1:0]     out_pixels,
  output logic                             out_last,
  output logic                             busy,
  output logic                             done
);
  localparam int P     = PIX_PER_CLK;
  localparam int R     = KSIZE / 2;
  localparam int NT    = KSIZE * KSIZE;
  localparam int PW    = DATA_W + COEF_W + 1;
  localparam int DEPTH = MAX_W / P;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SHW   = $clog2(P);
  localparam int RW    = ACC_W + 33;
  localparam logic signed [RW-1:0] SAT_MAX = (RW'(1) <<< (OUT_W-1)) - RW'(1);
  localparam logic signed [RW-1:0] SAT_MIN = -(RW'(1) <<< (OUT_W-1));

  localparam logic [2:0] S_IDLE = 3'd0, S_FILL = 3'd1, S_RUN = 3'd2, S_FLUSH = 3'd3, S_DONE = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [15:0]            col_q, col_d, nb_q, nb_d, cfg_h_q, cfg_h_d;
  logic [16:0]            row_q, row_d;
  logic [4:0]             shift_q, shift_d;
  logic [NT*COEF_W-1:0]   kernel_q, kernel_d;
  logic                   bubble_q, bubble_d, flush_end_q, flush_end_d;
  logic                   v1_q, v1_d, last1_q, last1_d;
  logic                   out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [P*OUT_W-1:0]     out_pixels_q, out_pixels_d, sat_pix;

  logic [P*DATA_W-1:0]    lb_mem [KSIZE-1][DEPTH];
  logic [DATA_W-1:0]      col_vec [KSIZE][P];
  logic [DATA_W-1:0]      left_q [KSIZE][P], left_d [KSIZE][P];
  logic [DATA_W-1:0]      mid_q [KSIZE][P], mid_d [KSIZE][P];
  logic [DATA_W-1:0]      wrow [KSIZE][3*P];
  logic signed [PW-1:0]   prod_q [P][NT], prod_d [P][NT];
  logic signed [ACC_W-1:0] acc [P];
  logic signed [RW-1:0]   ext [P];

  logic stall, adv, step, bub, emit, emit_last;

  always_comb begin
    stall     = out_valid_q && !out_ready;
    adv       = !stall;
    in_ready  = (state_q == S_FILL || state_q == S_RUN) && !bubble_q && adv;
    step      = (in_ready && in_valid) ||
                (state_q == S_FLUSH && !flush_end_q && !bubble_q && adv);
    bub       = bubble_q && adv;
    emit      = (bub || (step && col_q != 16'd0)) && (row_q >= 17'(R));
    emit_last = bub && (row_q + 17'd1 == {1'b0, cfg_h_q} + 17'(R));
  end

  // Window row k holds image row (row_q - (KSIZE-1-k)); rows outside the tile read as zero.
  always_comb begin
    for (int k = 0; k < KSIZE-1; k++)
      for (int p = 0; p < P; p++)
        col_vec[k][p] = lb_mem[KSIZE-2-k][col_q[AW-1:0]][p*DATA_W +: DATA_W];
    for (int p = 0; p < P; p++)
      col_vec[KSIZE-1][p] = in_pixels[p*DATA_W +: DATA_W];
    for (int k = 0; k < KSIZE; k++)
      for (int p = 0; p < P; p++)
        if (row_q < 17'(KSIZE-1-k) || row_q >= {1'b0, cfg_h_q} + 17'(KSIZE-1-k))
          col_vec[k][p] = '0;
  end

  always_comb begin
    left_d = left_q;
    mid_d  = mid_q;
    for (int k = 0; k < KSIZE; k++) begin
      for (int p = 0; p < P; p++) begin
        wrow[k][p]       = left_q[k][p];
        wrow[k][P+p]     = mid_q[k][p];
        wrow[k][2*P+p]   = bubble_q ? '0 : col_vec[k][p];
        if (step) begin
          left_d[k][p] = (col_q == 16'd0) ? '0 : mid_q[k][p];
          mid_d[k][p]  = col_vec[k][p];
        end
      end
    end
    for (int p = 0; p < P; p++)
      for (int ky = 0; ky < KSIZE; ky++)
        for (int kx = 0; kx < KSIZE; kx++)
          prod_d[p][ky*KSIZE+kx] = PW'($signed({1'b0, wrow[ky][P+p+kx-R]})) *
                                   PW'($signed(kernel_q[(ky*KSIZE+kx)*COEF_W +: COEF_W]));
  end

  always_comb begin
    sat_pix = '0;
    for (int p = 0; p < P; p++) begin
      acc[p] = '0;
      for (int t = 0; t < NT; t++)
        acc[p] = acc[p] + ACC_W'(prod_q[p][t]);
      ext[p] = RW'(acc[p]);
      if (shift_q != 5'd0)
        ext[p] = ext[p] + (RW'(1) << (shift_q - 5'd1));
      ext[p] = ext[p] >>> shift_q;
`ifdef TILE_CONV2D_RELU_EN
      if (ext[p] < 0)
        ext[p] = '0;
`endif
      if (ext[p] > SAT_MAX)
        sat_pix[p*OUT_W +: OUT_W] = SAT_MAX[OUT_W-1:0];
      else if (ext[p] < SAT_MIN)
        sat_pix[p*OUT_W +: OUT_W] = SAT_MIN[OUT_W-1:0];
      else
        sat_pix[p*OUT_W +: OUT_W] = ext[p][OUT_W-1:0];
    end
    v1_d         = adv ? emit : v1_q;
    last1_d      = adv ? emit_last : last1_q;
    out_valid_d  = adv ? v1_q : out_valid_q;
    out_last_d   = adv ? (v1_q && last1_q) : out_last_q;
    out_pixels_d = adv ? (v1_q ? sat_pix : '0) : out_pixels_q;
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    nb_d        = nb_q;
    cfg_h_d     = cfg_h_q;
    shift_d     = shift_q;
    kernel_d    = kernel_q;
    bubble_d    = bubble_q;
    flush_end_d = flush_end_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d     = S_FILL;
        nb_d        = cfg_w >> SHW;
        cfg_h_d     = cfg_h;
        shift_d     = cfg_shift;
        kernel_d    = kernel;
        col_d       = '0;
        row_d       = '0;
        bubble_d    = 1'b0;
        flush_end_d = 1'b0;
      end
      S_FILL, S_RUN, S_FLUSH: begin
        if (step) begin
          if (col_q == nb_q - 16'd1) begin
            col_d    = '0;
            bubble_d = 1'b1;
          end else begin
            col_d = col_q + 16'd1;
          end
        end
        // The row-end bubble flushes the last beat of the row and advances the row counter.
        if (bub) begin
          bubble_d = 1'b0;
          row_d    = row_q + 17'd1;
          if (state_q == S_FLUSH) begin
            if (emit_last) flush_end_d = 1'b1;
          end else if (row_d == {1'b0, cfg_h_q}) begin
            state_d = S_FLUSH;
          end else if (row_d >= 17'(R)) begin
            state_d = S_RUN;
          end
        end
        if (state_q == S_FLUSH && out_valid_q && out_ready && out_last_q)
          state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      nb_q         <= '0;
      cfg_h_q      <= '0;
      shift_q      <= '0;
      kernel_q     <= '0;
      bubble_q     <= 1'b0;
      flush_end_q  <= 1'b0;
      v1_q         <= 1'b0;
      last1_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_pixels_q <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      nb_q         <= nb_d;
      cfg_h_q      <= cfg_h_d;
      shift_q      <= shift_d;
      kernel_q     <= kernel_d;
      bubble_q     <= bubble_d;
      flush_end_q  <= flush_end_d;
      v1_q         <= v1_d;
      last1_q      <= last1_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_pixels_q <= out_pixels_d;
    end
  end

  always_ff @(posedge clk) begin
    left_q <= left_d;
    mid_q  <= mid_d;
    if (adv) prod_q <= prod_d;
    if (step) begin
      lb_mem[0][col_q[AW-1:0]] <= in_pixels;
      for (int j = 1; j < KSIZE-1; j++)
        lb_mem[j][col_q[AW-1:0]] <= lb_mem[j-1][col_q[AW-1:0]];
    end
  end

  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_pixels = out_pixels_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_tile_conv2d_stream.sv
// tb/tb_tile_conv2d_stream.sv - scoreboard bench for tile_conv2d_stream against a direct convolution model
module tb_tile_conv2d_stream;
  localparam int P  = 8;
  localparam int OW = P * 16;

  logic            clk, rst, start, in_valid, in_ready, out_valid, out_ready, out_last, busy, done;
  logic [15:0]     cfg_w, cfg_h;
  logic [4:0]      cfg_shift;
  logic [71:0]     kernel;
  logic [P*8-1:0]  in_pixels;
  logic [OW-1:0]   out_pixels;

  tile_conv2d_stream dut (
    .clk(clk), .rst(rst), .start(start), .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_shift(cfg_shift),
    .kernel(kernel), .in_valid(in_valid), .in_ready(in_ready), .in_pixels(in_pixels),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixels(out_pixels), .out_last(out_last),
    .busy(busy), .done(done)
  );

  int pass_cnt = 0, chk_cnt = 0;
  int img [4096];
  int kern [9];
  logic [OW-1:0] exp_q [$];
  logic          last_q [$];
  int n_out = 0, done_cnt = 0, cyc_cnt = 0, last_cyc = -100, rdy_mode = 0;
  logic          was_stall = 1'b0;
  logic [OW+1:0] held = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] expv);
    chk_cnt++;
    if (obs === expv) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  function automatic int model_px(int r, int c, int w, int h, int sh);
    longint acc = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (r+dy >= 0 && r+dy < h && c+dx >= 0 && c+dx < w)
          acc += longint'(img[(r+dy)*w + c+dx]) * longint'(kern[(dy+1)*3 + dx+1]);
    if (sh > 0) acc += longint'(1) << (sh-1);
    acc = acc >>> sh;
`ifdef TILE_CONV2D_RELU_EN
    if (acc < 0) acc = 0;
`endif
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return int'(acc);
  endfunction

  // Output monitor: drives out_ready, pops the scoreboard on every transfer.
  initial begin
    logic [OW-1:0] e;
    logic          l;
    forever begin
      @(negedge clk);
      out_ready = (rdy_mode != 0) ? ($urandom_range(1) == 1) : 1'b1;
      #1;
      cyc_cnt++;
      if (was_stall) check("stall_hold", {out_valid, out_pixels, out_last}, held);
      if (done) begin
        done_cnt++;
        check("done_after_last", cyc_cnt - last_cyc, 1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          l = last_q.pop_front();
          check("pixels", out_pixels, e);
          check("last", out_last, l);
        end
        if (out_last) last_cyc = cyc_cnt;
        n_out++;
      end
      was_stall = out_valid && !out_ready;
      held = {out_valid, out_pixels, out_last};
    end
  end

  task automatic run_tile(input int w, input int h, input int sh, input int vprob,
                          input int abort_at, input int restart);
    int nb, total, b, cyc, t, dbase, nbase;
    logic [OW-1:0] v;
    nb = w / P;
    total = nb * h;
    for (int r = 0; r < h; r++)
      for (int cb = 0; cb < nb; cb++) begin
        for (int p = 0; p < P; p++) v[p*16 +: 16] = 16'(model_px(r, cb*P+p, w, h, sh));
        exp_q.push_back(v);
        last_q.push_back(r == h-1 && cb == nb-1);
      end
    dbase = done_cnt;
    nbase = n_out;
    @(negedge clk);
    cfg_w = 16'(w); cfg_h = 16'(h); cfg_shift = 5'(sh);
    for (int i = 0; i < 9; i++) kernel[i*8 +: 8] = 8'(kern[i]);
    start = 1'b1;
    b = 0;
    cyc = 0;
    while (b < total && cyc < 20000) begin
      @(negedge clk);
      start = (restart != 0 && cyc == 0);
      if (restart != 0 && cyc == 0) begin
        cfg_h = 16'd5; cfg_shift = 5'd3; kernel = '0;
      end
      if (abort_at > 0 && n_out - nbase >= abort_at) break;
      in_valid = (int'($urandom_range(99)) < vprob);
      for (int p = 0; p < P; p++) in_pixels[p*8 +: 8] = 8'(img[(b/nb)*w + (b%nb)*P + p]);
      #2;
      if (in_valid && in_ready) b++;
      cyc++;
    end
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    if (abort_at > 0) begin
      t = 0;
      while (n_out - nbase < abort_at && t < 2000) begin @(negedge clk); t++; end
      check("abort_reached", n_out - nbase >= abort_at, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      last_q.delete();
      repeat (5) @(negedge clk);
      check("abort_no_done", done_cnt, dbase);
      check("abort_busy", busy, 0);
      check("abort_out_valid", out_valid, 0);
      check("abort_out_pixels", out_pixels, 0);
    end else begin
      check("input_accepted", b, total);
      t = 0;
      while (done_cnt == dbase && t < 20000) begin @(negedge clk); t++; end
      repeat (3) @(negedge clk);
      check("done_pulses", done_cnt, dbase + 1);
      check("beat_count", n_out - nbase, total);
      check("queue_drained", exp_q.size(), 0);
      check("idle_after", busy, 0);
    end
  endtask

  task automatic fill_img(input int w, input int h, input int val);
    for (int i = 0; i < w*h; i++) img[i] = val;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_pixels = '0; out_ready = 1'b1;
    cfg_w = '0; cfg_h = '0; cfg_shift = '0; kernel = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pixels", out_pixels, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    fill_img(8, 8, 1);
    for (int i = 0; i < 9; i++) kern[i] = 1;
    run_tile(8, 8, 0, 100, 0, 0);

    fill_img(16, 4, 0);
    img[3*16 + 4] = 255;
    kern = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    run_tile(16, 4, 4, 80, 0, 0);

    for (int i = 0; i < 4096; i++) img[i] = int'($urandom_range(255));
    for (int i = 0; i < 9; i++) kern[i] = int'($urandom_range(255)) - 128;
    rdy_mode = 1;
    run_tile(64, 64, 6, 60, 0, 0);
    rdy_mode = 0;

    fill_img(16, 4, 255);
    for (int i = 0; i < 9; i++) kern[i] = 127;
    run_tile(16, 4, 0, 100, 0, 0);
    for (int i = 0; i < 9; i++) kern[i] = -128;
    run_tile(16, 4, 0, 100, 0, 0);

    fill_img(8, 16, 1);
    for (int i = 0; i < 9; i++) kern[i] = 1;
    run_tile(8, 16, 0, 100, 10, 0);
    fill_img(8, 2, 1);
    run_tile(8, 2, 0, 100, 0, 0);

    fill_img(8, 1, 1);
    run_tile(8, 1, 0, 100, 0, 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
